// File: rtl/if_pkg.sv
// Shared constants for the MIPS instruction fetch stage: FSM encoding,
// NOP encoding and the sequential PC increment.
package if_pkg;

    localparam logic [1:0] IF_LOAD   = 2'd0;
    localparam logic [1:0] IF_RUN    = 2'd1;
    localparam logic [1:0] IF_HALTED = 2'd2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int unsigned PC_INC   = 4;

endpackage

// File: rtl/if_boot_assembler.sv
// Packs bootloader bytes MSB-first into instruction words and strobes
// word_ready_o on the byte that completes a word.
module if_boot_assembler #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               clear_i,
    input  logic [NB_BYTE-1:0] byte_i,
    input  logic               valid_i,
    output logic [NB_DATA-1:0] word_o,
    output logic               word_ready_o
);

    localparam int BPW = NB_DATA / NB_BYTE;
    localparam int CW  = $clog2(BPW) + 1;

    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NB_DATA-1:0] shifted;

    generate
        if (BPW == 1) begin : g_single
            assign shifted = byte_i;
        end else begin : g_multi
            assign shifted = {shift_q[NB_DATA-NB_BYTE-1:0], byte_i};
        end
    endgenerate

    // The completed word is taken straight from the shifter input so the
    // RAM write lands on the same edge as the last byte.
    assign word_o = shifted;

    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        word_ready_o = 1'b0;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (en_i && valid_i) begin
            shift_d = shifted;
            if (cnt_q == CW'(BPW - 1)) begin
                cnt_d        = '0;
                word_ready_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: boot-loaded instruction RAM, PC with redirect/stall/flush,
// registered IF/ID. Optional single-step mode under `IF_STEP_MODE_EN.
module instruction_fetch_stage
    import if_pkg::*;
#(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 MEM_DEPTH = 256,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NB_BYTE-1:0]           i_boot_byte,
    input  logic                         i_boot_valid,
    input  logic                         i_start,
    input  logic                         i_stall,
    input  logic                         i_branch_taken,
    input  logic [NB_DATA-1:0]           i_branch_target,
    input  logic                         i_flush,
    input  logic                         i_step,
    output logic [NB_DATA-1:0]           o_instruction,
    output logic [NB_DATA-1:0]           o_pc_plus4,
    output logic [NB_DATA-1:0]           o_pc,
    output logic                         o_valid,
    output logic                         o_is_end,
    output logic [$clog2(MEM_DEPTH):0]   o_loaded_words,
    output logic                         o_load_overflow,
    output logic [1:0]                   o_state
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [NB_DATA-1:0] NOP = NB_DATA'(NOP_WORD);
    localparam logic [NB_DATA-1:0] INC = NB_DATA'(PC_INC);

    logic [1:0]         state_q, state_d;
    logic [NB_DATA-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic [NB_DATA-1:0] pc4_q, pc4_d;
    logic               valid_q, valid_d;
    logic               end_q, end_d;
    logic [LW-1:0]      loaded_q, loaded_d;
    logic               ovf_q, ovf_d;

    logic [NB_DATA-1:0] boot_word;
    logic               boot_ready;
    logic               mem_full;
    logic               wr_en;

    logic [NB_DATA-1:0] mem [MEM_DEPTH];

    if_boot_assembler #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_asm (
        .clk_i        (i_clk),
        .rst_i        (i_reset),
        .en_i         (state_q == IF_LOAD && !i_start),
        .clear_i      (state_q == IF_LOAD && i_start),
        .byte_i       (i_boot_byte),
        .valid_i      (i_boot_valid),
        .word_o       (boot_word),
        .word_ready_o (boot_ready)
    );

    assign mem_full = (loaded_q == LW'(MEM_DEPTH));
    assign wr_en    = boot_ready && !mem_full;

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[loaded_q[AW-1:0]] <= boot_word;
    end

    // Any PC beyond the loaded image, including above the RAM window,
    // reads as the end marker so a runaway program stops itself.
    logic [AW-1:0]      fetch_idx;
    logic               fetch_in_range;
    logic [NB_DATA-1:0] fetch_word;
    logic [NB_DATA-1:0] pc_plus4;
    logic               fetch_halt;
    logic               step_ok;

    assign fetch_idx      = pc_q[AW+1:2];
    assign fetch_in_range = (pc_q[NB_DATA-1:AW+2] == '0) && ({1'b0, fetch_idx} < loaded_q);
    assign fetch_word     = fetch_in_range ? mem[fetch_idx] : HALT_WORD;
    assign fetch_halt     = (fetch_word == HALT_WORD);
    assign pc_plus4       = pc_q + INC;

`ifdef IF_STEP_MODE_EN
    assign step_ok = i_step;
`else
    logic unused_step;
    assign unused_step = i_step;
    assign step_ok     = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        end_d    = end_q;
        loaded_d = loaded_q;
        ovf_d    = ovf_q;

        if (wr_en)                loaded_d = loaded_q + 1'b1;
        if (boot_ready && mem_full) ovf_d  = 1'b1;

        case (state_q)
            IF_LOAD: begin
                if (i_start) state_d = IF_RUN;
            end
            IF_RUN: begin
                if (i_branch_taken) begin
                    pc_d    = i_branch_target;
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    end_d   = 1'b0;
                end else if (i_stall) begin
                    if (i_flush) begin
                        instr_d = NOP;
                        pc4_d   = '0;
                        valid_d = 1'b0;
                        end_d   = 1'b0;
                    end
                end else if (!step_ok || (fetch_halt && i_flush)) begin
                    // PC stays on the halt word under flush so it is re-fetched.
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    end_d   = 1'b0;
                end else if (fetch_halt) begin
                    instr_d = HALT_WORD;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    end_d   = 1'b1;
                    state_d = IF_HALTED;
                end else begin
                    pc_d    = pc_plus4;
                    instr_d = i_flush ? NOP : fetch_word;
                    pc4_d   = i_flush ? '0 : pc_plus4;
                    valid_d = !i_flush;
                    end_d   = 1'b0;
                end
            end
            IF_HALTED: begin
                instr_d = NOP;
                pc4_d   = '0;
                valid_d = 1'b0;
            end
            default: state_d = IF_LOAD;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IF_LOAD;
            pc_q     <= '0;
            instr_q  <= NOP;
            pc4_q    <= '0;
            valid_q  <= 1'b0;
            end_q    <= 1'b0;
            loaded_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
            end_q    <= end_d;
            loaded_q <= loaded_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_instruction   = instr_q;
    assign o_pc_plus4      = pc4_q;
    assign o_pc            = pc_q;
    assign o_valid         = valid_q;
    assign o_is_end        = end_q;
    assign o_loaded_words  = loaded_q;
    assign o_load_overflow = ovf_q;
    assign o_state         = state_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed scoreboard bench for instruction_fetch_stage (small RAM depth).
module tb_instruction_fetch_stage;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b0;
    logic [7:0]        i_boot_byte = '0;
    logic              i_boot_valid = 1'b0;
    logic              i_start = 1'b0;
    logic              i_stall = 1'b0;
    logic              i_branch_taken = 1'b0;
    logic [31:0]       i_branch_target = '0;
    logic              i_flush = 1'b0;
    logic              i_step = 1'b1;
    logic [31:0]       o_instruction;
    logic [31:0]       o_pc_plus4;
    logic [31:0]       o_pc;
    logic              o_valid;
    logic              o_is_end;
    logic [LW-1:0]     o_loaded_words;
    logic              o_load_overflow;
    logic [1:0]        o_state;

    instruction_fetch_stage #(
        .NB_DATA   (32),
        .NB_BYTE   (8),
        .MEM_DEPTH (DEPTH),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_boot_byte     (i_boot_byte),
        .i_boot_valid    (i_boot_valid),
        .i_start         (i_start),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_flush         (i_flush),
        .i_step          (i_step),
        .o_instruction   (o_instruction),
        .o_pc_plus4      (o_pc_plus4),
        .o_pc            (o_pc),
        .o_valid         (o_valid),
        .o_is_end        (o_is_end),
        .o_loaded_words  (o_loaded_words),
        .o_load_overflow (o_load_overflow),
        .o_state         (o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc4;
        logic        is_end;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_mis = 0;
    string cur = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s/%s: observed %0h expected %0h", cur, tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc4, input logic is_end);
        exp_t e;
        e.ins = ins; e.pc4 = pc4; e.is_end = is_end;
        sb.push_back(e);
    endtask

    // Advance one edge, sample 1ns later, retire one expectation per valid output.
    task automatic tick();
        exp_t e;
        @(posedge i_clk);
        #1;
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("sb_pending", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("ins", o_instruction, e.ins);
                chk("is_end", 32'(o_is_end), 32'(e.is_end));
                if (!e.is_end) chk("pc4", o_pc_plus4, e.pc4);
            end
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        #2;
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_ins", o_instruction, 32'd0);
        chk("rst_pc4", o_pc_plus4, 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_end", 32'(o_is_end), 32'd0);
        chk("rst_loaded", 32'(o_loaded_words), 32'd0);
        chk("rst_ovf", 32'(o_load_overflow), 32'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        sb.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_boot_byte  = b;
        i_boot_valid = 1'b1;
        tick();
        i_boot_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 3; i >= 0; i--) send_byte(t[i*8 +: 8]);
    endtask

    task automatic start_run();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_state", 32'(o_state), 32'd1);
    endtask

    initial begin
        // Basic load and run to halt
        cur = "basic";
        do_reset();
        send_word(32'h2008_0005);
        send_word(32'hFFFF_FFFF);
        chk("loaded", 32'(o_loaded_words), 32'd2);
        start_run();
        push(32'h2008_0005, 32'd4, 1'b0);
        push(32'hFFFF_FFFF, 32'd0, 1'b1);
        tick();
        tick();
        chk("halt_state", 32'(o_state), 32'd2);
        chk("halt_pc", o_pc, 32'd4);
        tick();
        chk("post_halt_valid", 32'(o_valid), 32'd0);
        chk("post_halt_end", 32'(o_is_end), 32'd1);
        chk("post_halt_ins", o_instruction, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Stall holds PC and IF/ID (also exercises async reset out of HALTED)
        cur = "stall";
        do_reset();
        send_word(32'hAAAA_0001);
        send_word(32'hBBBB_0002);
        send_word(32'hCCCC_0003);
        start_run();
        push(32'hAAAA_0001, 32'd4, 1'b0);
        push(32'hAAAA_0001, 32'd4, 1'b0);
        push(32'hAAAA_0001, 32'd4, 1'b0);
        push(32'hBBBB_0002, 32'd8, 1'b0);
        push(32'hCCCC_0003, 32'd12, 1'b0);
        push(32'hFFFF_FFFF, 32'd0, 1'b1);
        tick();
        i_stall = 1'b1;
        tick();
        chk("stall_pc1", o_pc, 32'd4);
        tick();
        chk("stall_pc2", o_pc, 32'd4);
        i_stall = 1'b0;
        tick();
        tick();
        tick();
        chk("stall_end_pc", o_pc, 32'd12);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Branch wins over a halt being fetched
        cur = "branch";
        do_reset();
        send_word(32'h1111_0000);
        send_word(32'hFFFF_FFFF);
        send_word(32'h3333_0008);
        start_run();
        push(32'h1111_0000, 32'd4, 1'b0);
        push(32'h3333_0008, 32'd12, 1'b0);
        push(32'hFFFF_FFFF, 32'd0, 1'b1);
        tick();
        chk("pre_br_pc", o_pc, 32'd4);
        i_branch_taken  = 1'b1;
        i_branch_target = 32'd8;
        tick();
        i_branch_taken = 1'b0;
        chk("br_valid", 32'(o_valid), 32'd0);
        chk("br_ins", o_instruction, 32'd0);
        chk("br_state", 32'(o_state), 32'd1);
        chk("br_pc", o_pc, 32'd8);
        tick();
        tick();
        chk("br_halt_state", 32'(o_state), 32'd2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Overflow: DEPTH+1 words, last dropped, RAM[0] intact
        cur = "overflow";
        do_reset();
        for (int k = 0; k < DEPTH; k++) send_word(32'h5000_0000 + 32'(k));
        chk("full_ovf", 32'(o_load_overflow), 32'd0);
        send_word(32'hDEAD_BEEF);
        chk("ovf_loaded", 32'(o_loaded_words), 32'(DEPTH));
        chk("ovf_flag", 32'(o_load_overflow), 32'd1);
        start_run();
        push(32'h5000_0000, 32'd4, 1'b0);
        push(32'h5000_0001, 32'd8, 1'b0);
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Reset mid-word discards the partial bytes
        cur = "midreset";
        do_reset();
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset();
        send_word(32'h1234_5678);
        chk("mr_loaded", 32'(o_loaded_words), 32'd1);
        start_run();
        push(32'h1234_5678, 32'd4, 1'b0);
        push(32'hFFFF_FFFF, 32'd0, 1'b1);
        tick();
        tick();
        chk("mr_state", 32'(o_state), 32'd2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

`ifdef IF_STEP_MODE_EN
        cur = "step";
        do_reset();
        for (int k = 0; k < 5; k++) send_word(32'h7000_0000 + 32'(k));
        i_step = 1'b0;
        start_run();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                chk("nostep_valid", 32'(o_valid), 32'd0);
            end
            push(32'h7000_0000 + 32'(p), 32'((p + 1) * 4), 1'b0);
            i_step = 1'b1;
            tick();
            i_step = 1'b0;
        end
        tick();
        chk("nostep_valid", 32'(o_valid), 32'd0);
        chk("step_pc", o_pc, 32'd12);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        i_step = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Parametrised MIPS fetch stage: PC register, word-addressed instruction RAM filled byte-by-byte from the UART bootloader, branch/jump redirect, stall and flush, and a registered IF/ID output. It sits between the bootloader/debug unit and the decode stage. It adds depth/width parameters, on-chip byte-to-word assembly, a LOAD/RUN/HALTED state machine, out-of-range end detection and optional single-step.

## Interface
- NB_DATA, 32, instruction/PC width
- NB_BYTE, 8, bootloader byte width; NB_DATA must be a multiple of it
- MEM_DEPTH, 256, instruction RAM depth in words; power of two
- HALT_WORD, 32'hFFFF_FFFF, end-of-program encoding
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high
- i_boot_byte  in  NB_BYTE  bootloader byte
- i_boot_valid  in  1  byte strobe, one byte per cycle high
- i_start  in  1  LOAD→RUN request
- i_stall  in  1  hazard stall from decode
- i_branch_taken  in  1  redirect request
- i_branch_target  in  NB_DATA  byte address of redirect
- i_flush  in  1  squash IF/ID
- i_step  in  1  single-step pulse (used only with IF_STEP_MODE_EN)
- o_instruction  out  NB_DATA  IF/ID instruction
- o_pc_plus4  out  NB_DATA  IF/ID PC+4
- o_pc  out  NB_DATA  current fetch PC
- o_valid  out  1  IF/ID holds a real instruction
- o_is_end  out  1  IF/ID holds the end instruction
- o_loaded_words  out  $clog2(MEM_DEPTH)+1  words written
- o_load_overflow  out  1  sticky, write beyond MEM_DEPTH attempted
- o_state  out  2  LOAD=0, RUN=1, HALTED=2

## Operation
- Reset (async): state LOAD, PC=0, o_instruction=0 (NOP), o_pc_plus4=0, o_valid=0, o_is_end=0, o_loaded_words=0, o_load_overflow=0, byte counter=0. RAM contents are not cleared.
- LOAD: each i_boot_valid byte is shifted in MSB-first. On the NB_DATA/NB_BYTE-th byte, the word is written to RAM[o_loaded_words] and the count increments. At count==MEM_DEPTH the word is dropped and o_load_overflow is set. PC and IF/ID stay idle.
- LOAD→RUN on i_start; a partially assembled word is discarded. i_boot_valid is ignored outside LOAD.
- RUN fetch word = RAM[PC[log2(MEM_DEPTH)+1:2]] (combinational read). If the PC word index is ≥ o_loaded_words, the fetch word is forced to HALT_WORD. PC[1:0] is ignored.
- PC next-state priority:
  1. i_branch_taken: PC←i_branch_target, IF/ID←NOP, valid=0.
  2. i_stall: PC and IF/ID hold.
  3. Fetch word == HALT_WORD: IF/ID←HALT_WORD, o_is_end=1, o_valid=1; PC holds; state→HALTED.
  4. Otherwise: PC←PC+4, IF/ID←{fetch word, PC+4}, valid=1.
- i_flush alone: IF/ID←NOP, valid=0, is_end=0. PC follows the rules above. A halt is not recognised in a flush cycle.
- HALTED: PC frozen. The cycle after entry, IF/ID←NOP with valid=0 and o_is_end stays high (sticky) until reset. Only i_reset leaves HALTED.
- PC+4 wraps modulo 2^NB_DATA; an out-of-range PC ends the program via the rule above.

## Timing
- One-cycle fetch latency: the instruction at PC appears on o_instruction after the next rising edge.
- A redirect in cycle n makes the target fetched in cycle n+1; the target's instruction is valid after edge n+2.
- The write for the last byte of a word is visible to fetch from the following cycle.
- Reset asserted mid-load or mid-run returns all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- IF_STEP_MODE_EN defined: in RUN, rules 3–4 take effect only in cycles with i_step=1. Without i_step, IF/ID goes to NOP with valid=0 and PC holds. Branch and flush still act immediately.
- IF_STEP_MODE_EN undefined: i_step is ignored and the stage fetches every unstalled cycle.

## Structure
- Package if_pkg holds the state encoding (IF_LOAD, IF_RUN, IF_HALTED), NOP_WORD=0 and the PC increment constant 4.
- Sub-module if_boot_assembler holds the byte shifter, byte counter and word-ready strobe; it is reset by i_reset.
- The RAM is inferred in the top level as a write-synchronous, read-asynchronous array.

## Test plan
- Load 8 bytes 20 08 00 05 FF FF FF FF, then i_start → o_loaded_words=2; o_instruction=0x20080005 with o_pc_plus4=4, then 0xFFFFFFFF with o_is_end=1; state=HALTED, PC=4.
- Load 3 words, stall for 2 cycles on the second → PC=4 and o_instruction holds the first word for both cycles, then normal fetch resumes.
- i_branch_taken with target 0x8 while a halt is being fetched at PC 0x4 → no halt; IF/ID=NOP with valid=0; the next output is the word at 0x8.
- Write MEM_DEPTH+1 words → o_loaded_words=MEM_DEPTH, o_load_overflow=1, RAM[0] unchanged.
- Assert i_reset after 2 of 4 bytes, then load a full word → the word is assembled from the post-reset bytes only, and o_loaded_words=1.
- With IF_STEP_MODE_EN: 3 i_step pulses spaced 5 cycles apart → exactly 3 valid instructions, PC=12, and valid=0 in all non-step cycles.
